adder_pipe: RTL

- Parametrised, pipelined successor to the team's 4-bit combinational adder.
- Adds two WIDTH-bit operands plus carry-in, computing CHUNK bits per pipeline stage with the carry registered between stages.
- Produces a WIDTH+1-bit sum after a fixed latency.
- Valid/ready handshake on both sides so it drops into streaming datapaths, with a full-pipeline stall on backpressure.

---
 rtl/adder_pipe_pkg.sv | 17 +
 rtl/adder_pipe_stage.sv | 36 +++
 rtl/adder_pipe.sv | 130 +++++++++++++
 3 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the pipelined adder: default geometry, stage-count
// helper and the per-stage carry/valid record.
package adder_pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_CHUNK = 4;

  function automatic int unsigned stages(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 0 : width / chunk;
  endfunction

  typedef struct packed {
    logic carry;
    logic valid;
  } stage_ctl_t;

endpackage

// File: rtl/adder_pipe_stage.sv
// One CHUNK-bit slice of the pipelined adder: registers the partial sum,
// carry-out and slot valid bit, holding everything while en is low.
module adder_pipe_stage
  import adder_pipe_pkg::*;
#(
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             carry,
  input  logic             valid,
  output logic [CHUNK-1:0] sum,
  output stage_ctl_t       ctl
);

  logic [CHUNK:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      ctl <= '0;
    end else if (en) begin
      sum       <= total[CHUNK-1:0];
      ctl.carry <= total[CHUNK];
      ctl.valid <= valid;
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder with valid/ready on both sides and a global stall.
// Optional subtract mode (sub_i port) is enabled by defining ADDER_PIPE_SUB_EN.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
`ifdef ADDER_PIPE_SUB_EN
  input  logic             sub_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   s_o
);

  localparam int unsigned STAGES = stages(WIDTH, CHUNK);

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             carry0;

  logic [CHUNK-1:0] sum_q [STAGES];
  stage_ctl_t       ctl_q [STAGES];

  // [k][j]: operand chunk j (j > k) or partial sum j (j < k) as held after stage k.
  logic [CHUNK-1:0] a_dly [STAGES][STAGES];
  logic [CHUNK-1:0] b_dly [STAGES][STAGES];
  logic [CHUNK-1:0] p_dly [STAGES][STAGES];

  always_comb begin
    out_valid_o = ctl_q[STAGES-1].valid;
    adv         = !out_valid_o || out_ready_i;
    in_ready_o  = adv;
    accept      = in_valid_i && in_ready_o;
  end

  // Subtraction folds into the add path: invert B on entry and force carry-in.
  always_comb begin
`ifdef ADDER_PIPE_SUB_EN
    b_eff  = sub_i ? ~b_i : b_i;
    carry0 = sub_i ? 1'b1 : c_i;
`else
    b_eff  = b_i;
    carry0 = c_i;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        for (int unsigned j = 0; j < STAGES; j++) begin
          a_dly[k][j] <= '0;
          b_dly[k][j] <= '0;
          p_dly[k][j] <= '0;
        end
      end
    end else if (adv) begin
      for (int unsigned j = 1; j < STAGES; j++) begin
        a_dly[0][j] <= a_i[j*CHUNK +: CHUNK];
        b_dly[0][j] <= b_eff[j*CHUNK +: CHUNK];
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        for (int unsigned j = k + 1; j < STAGES; j++) begin
          a_dly[k][j] <= a_dly[k-1][j];
          b_dly[k][j] <= b_dly[k-1][j];
        end
        p_dly[k][k-1] <= sum_q[k-1];
        for (int unsigned j = 0; j + 1 < k; j++) begin
          p_dly[k][j] <= p_dly[k-1][j];
        end
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] a_k;
    logic [CHUNK-1:0] b_k;
    logic             carry_k;
    logic             valid_k;

    if (k == 0) begin : g_head
      always_comb begin
        a_k     = a_i[CHUNK-1:0];
        b_k     = b_eff[CHUNK-1:0];
        carry_k = carry0;
        valid_k = accept;
      end
    end else begin : g_body
      always_comb begin
        a_k     = a_dly[k-1][k];
        b_k     = b_dly[k-1][k];
        carry_k = ctl_q[k-1].carry;
        valid_k = ctl_q[k-1].valid;
      end
    end

    adder_pipe_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .clk  (clk_i),
      .rst_n(rst_ni),
      .en   (adv),
      .a    (a_k),
      .b    (b_k),
      .carry(carry_k),
      .valid(valid_k),
      .sum  (sum_q[k]),
      .ctl  (ctl_q[k])
    );
  end

  always_comb begin
    s_o = '0;
    s_o[WIDTH] = ctl_q[STAGES-1].carry;
    s_o[(STAGES-1)*CHUNK +: CHUNK] = sum_q[STAGES-1];
    for (int unsigned j = 0; j + 1 < STAGES; j++) begin
      s_o[j*CHUNK +: CHUNK] = p_dly[STAGES-1][j];
    end
  end

endmodule
